// File: rtl/step_sequencer.sv
// step_sequencer: parametrised iteration counter with START/BUSY/DONE handshake, stall and saturate/wrap modes.
// Define STEP_SEQ_ABORT_EN to add the ABORT input that cancels a running or held sequence.
module step_sequencer #(
    parameter int WIDTH = 3,
    parameter bit WRAP  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] LIMIT,
`ifdef STEP_SEQ_ABORT_EN
    input  logic             ABORT,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_lim;
    logic             w_abort;
`ifdef STEP_SEQ_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif
    assign last = (r_state == RUN) && (count == r_lim);
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_lim   <= '1;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (w_abort) begin
            r_state <= IDLE;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HOLD: if (START) begin
                    r_state <= RUN;
                    r_lim   <= LIMIT;
                    count   <= '0;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                end
                RUN: begin
                    // in wrap mode done is a single-cycle pulse, so clear it on every non-completing cycle
                    done <= ENABLE && last;
                    if (ENABLE) begin
                        if (!last) begin
                            count <= count + WIDTH'(1);
                        end else if (WRAP) begin
                            count <= '0;
                        end else begin
                            r_state <= HOLD;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: table-driven check of the saturating sequencer plus hand sequences for reset, wrap and abort.
module tb_step_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] limit = 3'd0;
    logic       abort = 1'b0;
    logic [2:0] c, wc;
    logic       b, la, d, wb, wla, wd;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    step_sequencer #(.WIDTH(3), .WRAP(1'b0)) dut (
        .CLK(clk), .RST(rst), .START(start), .ENABLE(enable), .LIMIT(limit),
`ifdef STEP_SEQ_ABORT_EN
        .ABORT(abort),
`endif
        .count(c), .busy(b), .last(la), .done(d)
    );

    step_sequencer #(.WIDTH(3), .WRAP(1'b1)) dut_w (
        .CLK(clk), .RST(rst), .START(start), .ENABLE(enable), .LIMIT(limit),
`ifdef STEP_SEQ_ABORT_EN
        .ABORT(abort),
`endif
        .count(wc), .busy(wb), .last(wla), .done(wd)
    );

    typedef struct {
        logic       s;
        logic       e;
        logic [2:0] l;
        logic [2:0] c;
        logic       b;
        logic       la;
        logic       d;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic s, e, input logic [2:0] l, input logic [2:0] ec, input logic eb, ela, ed);
        tv.push_back('{s, e, l, ec, eb, ela, ed});
    endtask

    task automatic step(input logic s, e, input logic [2:0] l);
        start = s;
        enable = e;
        limit = l;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s {count,busy,last,done} got %b want %b", name, act, exp);
        end
    endtask

    initial begin
        // {count,busy,last,done} expected after each edge
        repeat (4) add(0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 7, 0, 1, 0, 0);
        for (int i = 1; i <= 6; i++) add(0, 1, 0, 3'(i), 1, 0, 0);
        add(0, 1, 0, 7, 1, 1, 0);
        repeat (4) add(0, 1, 0, 7, 0, 0, 1);
        add(1, 1, 7, 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) add(0, 1, 0, 3'(i), 1, 0, 0);
        add(0, 0, 0, 3, 1, 0, 0);
        add(1, 0, 2, 3, 1, 0, 0);
        add(0, 0, 0, 3, 1, 0, 0);
        add(1, 1, 2, 4, 1, 0, 0);
        add(0, 1, 0, 5, 1, 0, 0);
        add(0, 1, 0, 6, 1, 0, 0);
        add(0, 1, 0, 7, 1, 1, 0);
        add(0, 1, 0, 7, 0, 0, 1);
        add(1, 1, 2, 0, 1, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0);
        add(0, 1, 0, 2, 1, 1, 0);
        add(0, 1, 0, 2, 0, 0, 1);
        add(0, 1, 5, 2, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1);

        repeat (2) step(0, 0, 0);
        chk("reset", {c, b, la, d}, 6'b000000);
        rst = 1'b0;
        foreach (tv[i]) begin
            step(tv[i].s, tv[i].e, tv[i].l);
            chk($sformatf("vec%0d", i), {c, b, la, d}, {tv[i].c, tv[i].b, tv[i].la, tv[i].d});
        end

        step(1, 1, 7);
        repeat (4) step(0, 1, 0);
        chk("pre_rst_count4", {c, b, la, d}, {3'd4, 3'b100});
        rst = 1'b1;
        step(1, 1, 7);
        chk("mid_rst", {c, b, la, d}, 6'b000000);
        rst = 1'b0;
        step(0, 1, 0);
        chk("post_rst_idle", {c, b, la, d}, 6'b000000);

        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        step(1, 1, 3);
        chk("wrap_start", {wc, wb, wla, wd}, 6'b000100);
        for (int j = 1; j <= 12; j++) begin
            step(0, 1, 0);
            chk($sformatf("wrap%0d", j), {wc, wb, wla, wd}, {3'(j % 4), 1'b1, (j % 4) == 3, (j % 4) == 0});
        end

`ifdef STEP_SEQ_ABORT_EN
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        step(1, 1, 7);
        repeat (5) step(0, 1, 0);
        chk("pre_abort_count5", {c, b, la, d}, {3'd5, 3'b100});
        abort = 1'b1;
        step(1, 1, 7);
        chk("abort", {c, b, la, d}, 6'b000000);
        abort = 1'b0;
        repeat (3) begin
            step(0, 1, 0);
            chk("post_abort", {c, b, la, d}, 6'b000000);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
